// File: rtl/io_pkg.sv
// Shared types for the IN/OUT port controller: FSM states, error codes and defaults.
package io_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        IN_WAIT   = 3'd1,
        IN_ACK    = 3'd2,
        OUT_WAIT  = 3'd3,
        OUT_DRIVE = 3'd4,
        OUT_REL   = 3'd5,
        DONE      = 3'd6
    } io_state_e;

    typedef enum logic [1:0] {
        IO_ERR_NONE    = 2'd0,
        IO_ERR_TIMEOUT = 2'd1
    } io_err_e;

    // States in which the controller is waiting on a device and the timeout runs.
    function automatic logic is_wait_state(input io_state_e s);
        return (s == IN_WAIT) || (s == IN_ACK) || (s == OUT_WAIT) ||
               (s == OUT_DRIVE) || (s == OUT_REL);
    endfunction

endpackage

// File: rtl/hs_sync.sv
// Multi-flop synchronizer for one asynchronous handshake pin; clears to 0 on reset.
module hs_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/io_port_ctrl.sv
// Sequences IN/OUT device transfers with four-phase handshakes and stalls the pipeline meanwhile.
// Handshake: each phase raises our strobe and waits for the synchronized device level to change.
module io_port_ctrl
    import io_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic              g_clk,
    input  logic              g_clr,
    input  logic              io_rd,
    input  logic              io_wr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic [DATA_W-1:0] io_rdata,
    output logic              io_busy,
    output logic              io_done,
    output logic              io_err,
    input  logic              in_dev_hs,
    output logic              in_dev_ack,
    input  logic [DATA_W-1:0] input_bus,
    input  logic              out_dev_hs,
    output logic              out_dev_req,
    input  logic              out_dev_ack,
    output logic [DATA_W-1:0] output_bus,
    output io_state_e         dbg_state_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic in_hs_s, out_hs_s, out_ack_s;

    hs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_in_hs (
        .clk_i(g_clk), .clr_i(g_clr), .d_i(in_dev_hs), .q_o(in_hs_s)
    );
    hs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_out_hs (
        .clk_i(g_clk), .clr_i(g_clr), .d_i(out_dev_hs), .q_o(out_hs_s)
    );
    hs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_out_ack (
        .clk_i(g_clk), .clr_i(g_clr), .d_i(out_dev_ack), .q_o(out_ack_s)
    );

    io_state_e         state_q, state_d;
    io_err_e           err_code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] obus_q, obus_d;
    logic              ack_q, ack_d, req_q, req_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic              timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && is_wait_state(state_q) && (cnt_q == CNT_LAST);

    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            obus_q  <= '0;
            ack_q   <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            obus_q  <= obus_d;
            ack_q   <= ack_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // A timeout overrides any progress made in the same cycle.
    always_comb begin
        state_d    = state_q;
        err_code_d = IO_ERR_NONE;
        case (state_q)
            IDLE: begin
                if (io_rd) begin
                    state_d = IN_WAIT;
                end else if (io_wr) begin
                    state_d = OUT_WAIT;
                end
            end
            IN_WAIT:   if (in_hs_s)    state_d = IN_ACK;
            IN_ACK:    if (!in_hs_s)   state_d = DONE;
            OUT_WAIT:  if (out_hs_s)   state_d = OUT_DRIVE;
            OUT_DRIVE: if (out_ack_s)  state_d = OUT_REL;
            OUT_REL:   if (!out_ack_s) state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (timeout_hit) begin
            state_d    = DONE;
            err_code_d = IO_ERR_TIMEOUT;
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_comb begin
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        wdata_d = wdata_q;
        obus_d  = obus_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (is_wait_state(state_q) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if ((state_q == IN_WAIT) && (state_d == IN_ACK)) begin
            rdata_d = input_bus;
        end
        if ((state_q == IDLE) && (state_d == OUT_WAIT)) begin
            wdata_d = io_wdata;
            obus_d  = '0;
        end
        if ((state_q == OUT_WAIT) && (state_d == OUT_DRIVE)) begin
            obus_d = wdata_q;
        end
        ack_d  = (state_d == IN_ACK);
        req_d  = (state_d == OUT_DRIVE);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        err_d  = (state_d == DONE) && (err_code_d == IO_ERR_TIMEOUT);
    end

    assign io_rdata    = rdata_q;
    assign io_busy     = busy_q;
    assign io_done     = done_q;
    assign io_err      = err_q;
    assign in_dev_ack  = ack_q;
    assign out_dev_req = req_q;
    assign output_bus  = obus_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed plus randomized bench for io_port_ctrl with a transfer-level reference model.
module tb_io_port_ctrl;
    import io_pkg::*;

    localparam int DW   = 8;
    localparam int SYNC = 2;
    localparam int TO   = 16;
    localparam int LAT  = SYNC + 1;

    logic          clk = 1'b0;
    logic          g_clr;
    logic          io_rd, io_wr;
    logic [DW-1:0] io_wdata, io_rdata;
    logic          io_busy, io_done, io_err;
    logic          in_dev_hs, in_dev_ack;
    logic [DW-1:0] input_bus;
    logic          out_dev_hs, out_dev_req, out_dev_ack;
    logic [DW-1:0] output_bus;
    io_state_e     dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [DW-1:0] exp_rdata;
    logic [DW-1:0] exp_obus;

    always #5 clk = ~clk;

    io_port_ctrl #(.DATA_W(DW), .SYNC_STAGES(SYNC), .TIMEOUT(TO)) dut (
        .g_clk(clk), .g_clr(g_clr), .io_rd(io_rd), .io_wr(io_wr),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .io_busy(io_busy),
        .io_done(io_done), .io_err(io_err), .in_dev_hs(in_dev_hs),
        .in_dev_ack(in_dev_ack), .input_bus(input_bus), .out_dev_hs(out_dev_hs),
        .out_dev_req(out_dev_req), .out_dev_ack(out_dev_ack),
        .output_bus(output_bus), .dbg_state_o(dbg_state)
    );

    always @(negedge clk) if (io_done === 1'b1) done_cnt++;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, want);
        end
    endtask

    task automatic chk8(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    // IN transfer: device raises hs after hs_dly cycles, drops it drop_dly cycles after ack.
    task automatic in_xfer(input logic [DW-1:0] d, input int hs_dly, input int drop_dly,
                           input bit also_wr, input bit poke);
        io_rd = 1'b1; io_wr = also_wr; io_wdata = DW'($urandom);
        tick(1);
        io_rd = 1'b0; io_wr = 1'b0;
        chk1("in_busy", io_busy, 1'b1);
        if (poke) begin
            io_rd = 1'b1; io_wr = 1'b1;
            tick(1);
            io_rd = 1'b0; io_wr = 1'b0;
            chk1("poke_req", out_dev_req, 1'b0);
        end
        repeat (hs_dly) begin
            tick(1);
            chk1("in_wait_ack", in_dev_ack, 1'b0);
        end
        in_dev_hs = 1'b1; input_bus = d;
        for (int k = 1; k <= LAT; k++) begin
            tick(1);
            chk1("in_ack_rise", in_dev_ack, k == LAT);
            chk1("in_no_req", out_dev_req, 1'b0);
        end
        exp_rdata = d;
        chk8("in_rdata", io_rdata, exp_rdata);
        repeat (drop_dly) begin
            tick(1);
            chk1("in_ack_hold", in_dev_ack, 1'b1);
        end
        in_dev_hs = 1'b0; input_bus = DW'($urandom);
        for (int k = 1; k <= LAT; k++) begin
            tick(1);
            chk1("in_done", io_done, k == LAT);
            chk1("in_ack_fall", in_dev_ack, k < LAT);
        end
        chk1("in_err", io_err, 1'b0);
        chk1("in_busy_done", io_busy, 1'b1);
        chk8("in_rdata_done", io_rdata, exp_rdata);
        chk8("in_obus", output_bus, exp_obus);
        tick(1);
        chk1("in_done_pulse", io_done, 1'b0);
        chk1("in_busy_low", io_busy, 1'b0);
    endtask

    // OUT transfer: device ready after hs_dly cycles, acks ack_dly cycles after req seen.
    task automatic out_xfer(input logic [DW-1:0] d, input int hs_dly, input int ack_dly);
        io_wr = 1'b1; io_wdata = d;
        tick(1);
        io_wr = 1'b0; io_wdata = DW'($urandom);
        chk1("out_busy", io_busy, 1'b1);
        repeat (hs_dly) begin
            tick(1);
            chk1("out_wait_req", out_dev_req, 1'b0);
        end
        out_dev_hs = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            tick(1);
            chk1("out_req_rise", out_dev_req, k == LAT);
        end
        exp_obus = d;
        chk8("out_bus", output_bus, exp_obus);
        repeat (ack_dly) begin
            tick(1);
            chk1("out_req_hold", out_dev_req, 1'b1);
            chk8("out_bus_hold", output_bus, exp_obus);
        end
        out_dev_ack = 1'b1; out_dev_hs = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            tick(1);
            chk1("out_req_fall", out_dev_req, k < LAT);
        end
        out_dev_ack = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            tick(1);
            chk1("out_done", io_done, k == LAT);
        end
        chk1("out_err", io_err, 1'b0);
        chk8("out_bus_done", output_bus, exp_obus);
        chk1("out_no_ack", in_dev_ack, 1'b0);
        tick(1);
        chk1("out_done_pulse", io_done, 1'b0);
        chk1("out_busy_low", io_busy, 1'b0);
    endtask

    initial begin
        int c0;
        logic [DW-1:0] d;
        g_clr = 1'b1; io_rd = 1'b0; io_wr = 1'b0; io_wdata = '0;
        in_dev_hs = 1'b0; input_bus = '0; out_dev_hs = 1'b0; out_dev_ack = 1'b0;
        exp_rdata = '0; exp_obus = '0;
        tick(3);
        chk1("rst_busy", io_busy, 1'b0);
        chk1("rst_done", io_done, 1'b0);
        chk1("rst_err", io_err, 1'b0);
        chk1("rst_ack", in_dev_ack, 1'b0);
        chk1("rst_req", out_dev_req, 1'b0);
        chk8("rst_rdata", io_rdata, exp_rdata);
        chk8("rst_obus", output_bus, exp_obus);
        chk_int("rst_state", int'(dbg_state), int'(IDLE));
        g_clr = 1'b0;
        tick(2);

        // Simultaneous rd+wr: IN only, output side untouched.
        in_xfer(8'h33, 1, 1, 1'b1, 1'b0);
        chk1("both_req", out_dev_req, 1'b0);
        chk8("both_obus", output_bus, 8'h00);
        tick(2);

        in_xfer(8'h0A, 0, 0, 1'b0, 1'b0);
        tick(2);
        out_xfer(8'h5C, 0, 4);
        tick(2);

        // IN timeout: no device response.
        io_rd = 1'b1; tick(1); io_rd = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            tick(1);
            chk1("to_in_done", io_done, k == TO);
            chk1("to_in_ack", in_dev_ack, 1'b0);
        end
        chk1("to_in_err", io_err, 1'b1);
        chk8("to_in_rdata", io_rdata, exp_rdata);
        tick(1);
        chk1("to_in_busy", io_busy, 1'b0);
        chk1("to_in_err_clr", io_err, 1'b0);
        tick(2);

        // OUT timeout: device ready but never acks.
        d = DW'($urandom);
        io_wr = 1'b1; io_wdata = d; tick(1); io_wr = 1'b0;
        out_dev_hs = 1'b1;
        tick(LAT);
        chk1("to_out_req_on", out_dev_req, 1'b1);
        exp_obus = d;
        for (int k = 1; k <= TO; k++) begin
            tick(1);
            chk1("to_out_req", out_dev_req, k < TO);
            chk1("to_out_done", io_done, k == TO);
        end
        chk1("to_out_err", io_err, 1'b1);
        chk8("to_out_obus", output_bus, exp_obus);
        out_dev_hs = 1'b0;
        tick(1);
        chk1("to_out_busy", io_busy, 1'b0);
        tick(3);

        // Requests during a busy IN are dropped.
        c0 = done_cnt;
        in_xfer(DW'($urandom), 2, 1, 1'b0, 1'b1);
        tick(4);
        chk_int("poke_one_done", done_cnt - c0, 1);
        chk1("poke_idle", io_busy, 1'b0);
        chk1("poke_no_req", out_dev_req, 1'b0);

        // Reset in OUT_DRIVE aborts without io_done.
        d = DW'($urandom) | 8'h01;
        io_wr = 1'b1; io_wdata = d; tick(1); io_wr = 1'b0;
        out_dev_hs = 1'b1;
        tick(LAT + 2);
        chk1("clr_pre_req", out_dev_req, 1'b1);
        c0 = done_cnt;
        g_clr = 1'b1;
        tick(1);
        exp_rdata = '0; exp_obus = '0;
        chk1("clr_req", out_dev_req, 1'b0);
        chk8("clr_obus", output_bus, exp_obus);
        chk1("clr_busy", io_busy, 1'b0);
        chk1("clr_done", io_done, 1'b0);
        g_clr = 1'b0; out_dev_hs = 1'b0;
        tick(4);
        chk_int("clr_no_done", done_cnt - c0, 0);
        in_xfer(DW'($urandom), 1, 2, 1'b0, 1'b0);
        tick(2);

        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                in_xfer(DW'($urandom), $urandom_range(0, 6), $urandom_range(0, 6), 1'b0, 1'b0);
            end else begin
                out_xfer(DW'($urandom), $urandom_range(0, 6), $urandom_range(0, 6));
            end
            tick($urandom_range(1, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
